// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: valid/ready request,
// programmable wait states, then a registered load-data or store-completion response.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_We,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_WData,
  input  logic [3:0]  Req_ByteEn,
  output logic        Resp_Valid,
  input  logic        Resp_Ready,
  output logic [31:0] Resp_RData,
  output logic        Resp_Err,
  output logic        Busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [ADDR_W-1:0] word_idx;
  logic              addr_err;
  logic [31:0]       mem_word;
  logic [3:0]        lane_we;

  assign word_idx = addr_q[ADDR_W+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);

  // One byte-wide array per lane so byte enables map onto independent write ports.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_lane [DEPTH];

    assign lane_we[gi] = (state_q == S_ACCESS) && we_q && !addr_err && be_q[gi];

    always_ff @(posedge Clk) begin
      if (lane_we[gi]) begin
        mem_lane[word_idx] <= wdata_q[8*gi +: 8];
      end
    end

    assign mem_word[8*gi +: 8] = mem_lane[word_idx];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (Req_Valid) begin
          we_d    = Req_We;
          addr_d  = Req_Addr;
          wdata_d = Req_WData;
          be_d    = Req_ByteEn;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACCESS: begin
        // Read sees the word as it was before this edge's write.
        err_d   = addr_err;
        rdata_d = (!addr_err && !we_q) ? mem_word : 32'h0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (Resp_Ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Req_Ready  = (state_q == S_IDLE);
  assign Busy       = (state_q != S_IDLE);
  assign Resp_Valid = (state_q == S_RESP);
  assign Resp_RData = rdata_q;
  assign Resp_Err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A uses the default wait states,
// instance B runs with no wait states for the reset-in-response case.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, rst_n_b, sel;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        a_ready, a_rvalid, a_err, a_busy;
  logic [31:0] a_rdata;
  logic        b_ready, b_rvalid, b_err, b_busy;
  logic [31:0] b_rdata;

  logic        o_ready, o_rvalid, o_err, o_busy;
  logic [31:0] o_rdata;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
    .Clk(clk), .Reset_n(rst_n_a),
    .Req_Valid(req_valid & ~sel), .Req_Ready(a_ready),
    .Req_We(req_we), .Req_Addr(req_addr), .Req_WData(req_wdata), .Req_ByteEn(req_be),
    .Resp_Valid(a_rvalid), .Resp_Ready(resp_ready & ~sel),
    .Resp_RData(a_rdata), .Resp_Err(a_err), .Busy(a_busy)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
    .Clk(clk), .Reset_n(rst_n_b),
    .Req_Valid(req_valid & sel), .Req_Ready(b_ready),
    .Req_We(req_we), .Req_Addr(req_addr), .Req_WData(req_wdata), .Req_ByteEn(req_be),
    .Resp_Valid(b_rvalid), .Resp_Ready(resp_ready & sel),
    .Resp_RData(b_rdata), .Resp_Err(b_err), .Busy(b_busy)
  );

  assign o_ready  = sel ? b_ready  : a_ready;
  assign o_rvalid = sel ? b_rvalid : a_rvalid;
  assign o_err    = sel ? b_err    : a_err;
  assign o_busy   = sel ? b_busy   : a_busy;
  assign o_rdata  = sel ? b_rdata  : a_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One full request/response; hold = cycles of response backpressure.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int hold, input int exp_lat);
    int n;
    int lat;
    n = 0;
    while (!o_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble the live inputs: only the latched copies may be used.
    req_valid = 1'b0; req_we = ~we; req_addr = 32'h0000_0044;
    req_wdata = ~wdata; req_be = 4'hF;
    lat = 0;
    while (!o_rvalid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!o_rvalid) check_eq({tag, "_timeout"}, o_rvalid, 1);
    if (exp_lat >= 0) check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_rdata"}, o_rdata, exp_rdata);
    check_eq({tag, "_err"}, o_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040;
      @(posedge clk); #1;
      check_eq({tag, "_bp_valid"}, o_rvalid, 1);
      check_eq({tag, "_bp_rdata"}, o_rdata, exp_rdata);
      check_eq({tag, "_bp_err"}, o_err, exp_err);
      check_eq({tag, "_bp_ready"}, o_ready, 0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_eq({tag, "_retire_busy"}, o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sel = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    rst_n_a = 1'b1; rst_n_b = 1'b1;

    // Reset state must appear asynchronously, before any clock edge.
    #2;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    #1;
    check_eq("rst_ready", o_ready, 1);
    check_eq("rst_rvalid", o_rvalid, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_rdata", o_rdata, 32'h0);
    check_eq("rst_err", o_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n_a = 1'b1; rst_n_b = 1'b1;

    txn("st10",   1'b1, 32'h10,   32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 0, 4);
    txn("ld10",   1'b0, 32'h10,   32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 0, 4);
    txn("st20a",  1'b1, 32'h20,   32'h1122_3344, 4'hF, 32'h0,         1'b0, 0, -1);
    txn("st20b",  1'b1, 32'h20,   32'hAABB_CCDD, 4'h5, 32'h0,         1'b0, 0, -1);
    txn("ld20",   1'b0, 32'h20,   32'h0,         4'h0, 32'h11BB_33DD, 1'b0, 0, -1);
    txn("ld06",   1'b0, 32'h6,    32'h0,         4'h0, 32'h0,         1'b1, 0, -1);
    txn("st00",   1'b1, 32'h0,    32'hCAFE_F00D, 4'hF, 32'h0,         1'b0, 0, -1);
    txn("st1000", 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 32'h0,         1'b1, 0, -1);
    txn("ld00",   1'b0, 32'h0,    32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 0, -1);
    txn("stbe0",  1'b1, 32'h10,   32'h0,         4'h0, 32'h0,         1'b0, 0, -1);
    txn("ld10b",  1'b0, 32'h10,   32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 0, -1);
    txn("bp",     1'b0, 32'h20,   32'h0,         4'h0, 32'h11BB_33DD, 1'b0, 5, -1);
    txn("postbp", 1'b0, 32'h10,   32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 0, 4);

    // Reset during WAIT drops the store.
    txn("st30z",  1'b1, 32'h30,   32'h0,         4'hF, 32'h0,         1'b0, 0, -1);
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55AA_55AA; req_be = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("abort_busy_pre", o_busy, 1);
    @(posedge clk); #1;
    rst_n_a = 1'b0;
    #1;
    check_eq("abort_busy", o_busy, 0);
    check_eq("abort_ready", o_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("abort_no_resp", o_rvalid, 0);
      if (i == 1) rst_n_a = 1'b1;
    end
    txn("ld30",   1'b0, 32'h30,   32'h0,         4'h0, 32'h0,         1'b0, 0, -1);

    // Zero-wait instance: reset in RESP keeps the committed store.
    sel = 1'b1;
    txn("b_st30z", 1'b1, 32'h30,  32'h0,         4'hF, 32'h0,         1'b0, 0, -1);
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55AA_55AA; req_be = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!o_rvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("b_in_resp", o_rvalid, 1);
    rst_n_b = 1'b0;
    #1;
    check_eq("b_abort_valid", o_rvalid, 0);
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("b_no_resp", o_rvalid, 0);
    txn("b_ld30", 1'b0, 32'h30,   32'h0,         4'h0, 32'h55AA_55AA, 1'b0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
